// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly behind the program counter. On a fetch request
// it latches the current PC as the memory word address, holds a read request
// until the memory answers, and captures the returned instruction word. A
// one-cycle o_instruction_DV pulse marks a new instruction. The control unit
// also uses this pulse as its PC load strobe.
//
// A flush (taken jump or trap) while a read is outstanding moves the block to
// DRAIN. In DRAIN it keeps the read request high until the stale response
// arrives, then throws that response away. Misaligned PCs are rejected without
// any bus access. A read that gets no answer within TIMEOUT_CYCLES raises a
// one-cycle bus fault.
//
// Ports
//   i_clk             rising-edge clock
//   i_rst_n           asynchronous active-low reset
//   i_PC              current PC from the program counter
//   i_fetch           fetch request (level, sampled only while idle)
//   i_flush           abort the current or pending fetch
//   o_mem_address     instruction memory word address
//   o_mem_read        read request, held until the response arrives
//   i_mem_data        read data
//   i_mem_DV          read data valid, one cycle per request
//   o_instruction     last fetched instruction
//   o_instruction_DV  one-cycle pulse: o_instruction is new
//   o_busy            high while a read is outstanding (WAIT or DRAIN)
//   o_misaligned      one-cycle pulse: fetch requested with i_PC[1:0] != 0
//   o_bus_fault       one-cycle pulse: read timed out
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] RESET_INSTR    = 32'h00000013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_PC,
   input  logic        i_fetch,
   input  logic        i_flush,
   output logic [31:0] o_mem_address,
   output logic        o_mem_read,
   input  logic [31:0] i_mem_data,
   input  logic        i_mem_DV,
   output logic [31:0] o_instruction,
   output logic        o_instruction_DV,
   output logic        o_busy,
   output logic        o_misaligned,
   output logic        o_bus_fault
);

   // The counter must be able to hold TIMEOUT_CYCLES. A flush taken on the
   // last WAIT cycle still increments the counter once, so it can reach that
   // value without wrapping.
   localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
   localparam logic [31:0]   RESET_ADDR = 32'h80000000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_r,  state_s;
   logic [CW-1:0] count_r,  count_s;
   logic [31:0]   address_r, address_s;
   logic          read_r,   read_s;
   logic [31:0]   instr_r,  instr_s;
   logic          instr_dv_r, instr_dv_s;
   logic          busy_r,   busy_s;
   logic          misaligned_r, misaligned_s;
   logic          fault_r,  fault_s;

   // Next-state and next-output logic for the fetch FSM.
   always_comb begin
      state_s      = state_r;
      count_s      = count_r;
      address_s    = address_r;
      read_s       = read_r;
      instr_s      = instr_r;
      instr_dv_s   = 1'b0;
      misaligned_s = 1'b0;
      fault_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (i_flush) begin
               // A redirect in the same cycle makes the requested PC stale.
               state_s = ST_IDLE;
            end else if (i_fetch && (i_PC[1:0] != 2'b00)) begin
               misaligned_s = 1'b1;
            end else if (i_fetch) begin
               address_s = i_PC;
               read_s    = 1'b1;
               count_s   = {CW{1'b0}};
               state_s   = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_WAIT: begin
            if (i_mem_DV && i_flush) begin
               read_s  = 1'b0;
               state_s = ST_IDLE;
            end else if (i_mem_DV) begin
               instr_s    = i_mem_data;
               instr_dv_s = 1'b1;
               read_s     = 1'b0;
               state_s    = ST_IDLE;
            end else if (i_flush) begin
               // This cycle counts toward the timeout. WAIT and DRAIN share
               // one budget of TIMEOUT_CYCLES cycles in total.
               count_s = count_r + ONE_COUNT;
               state_s = ST_DRAIN;
            end else if (count_r == LAST_COUNT) begin
               fault_s = 1'b1;
               read_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               count_s = count_r + ONE_COUNT;
            end
         end

         ST_DRAIN: begin
            read_s = 1'b1;
            if (i_mem_DV) begin
               read_s  = 1'b0;
               state_s = ST_IDLE;
            end else if (count_r >= LAST_COUNT) begin
               // A flush on the final WAIT cycle lands here with the count
               // already past LAST_COUNT. In that case leave on the first
               // DRAIN cycle.
               read_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               count_s = count_r + ONE_COUNT;
            end
         end

         default: begin
            read_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State and registered-output flops. Reset drops any outstanding read at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         count_r      <= {CW{1'b0}};
         address_r    <= RESET_ADDR;
         read_r       <= 1'b0;
         instr_r      <= RESET_INSTR;
         instr_dv_r   <= 1'b0;
         busy_r       <= 1'b0;
         misaligned_r <= 1'b0;
         fault_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         count_r      <= count_s;
         address_r    <= address_s;
         read_r       <= read_s;
         instr_r      <= instr_s;
         instr_dv_r   <= instr_dv_s;
         busy_r       <= busy_s;
         misaligned_r <= misaligned_s;
         fault_r      <= fault_s;
      end
   end

   assign o_mem_address    = address_r;
   assign o_mem_read       = read_r;
   assign o_instruction    = instr_r;
   assign o_instruction_DV = instr_dv_r;
   assign o_busy           = busy_r;
   assign o_misaligned     = misaligned_r;
   assign o_bus_fault      = fault_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed and randomized bench for instruction_fetch with TIMEOUT_CYCLES = 4.
// A fetch is described by the WAIT-relative cycle on which the memory answers,
// the cycle on which a flush arrives, and the response data. The expected
// outcome follows directly from the fetch rules:
//   - A response inside the timeout window with no earlier or simultaneous
//     flush is captured.
//   - A flush at or before the response discards the response.
//   - With no response, the fetch ends with a bus fault, or ends silently if
//     it was flushed.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int          T       = 4;
   localparam logic [31:0] RST_INS = 32'h00000013;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_PC;
   logic        i_fetch;
   logic        i_flush;
   logic [31:0] o_mem_address;
   logic        o_mem_read;
   logic [31:0] i_mem_data;
   logic        i_mem_DV;
   logic [31:0] o_instruction;
   logic        o_instruction_DV;
   logic        o_busy;
   logic        o_misaligned;
   logic        o_bus_fault;

   int          total;
   int          bad;
   logic [31:0] exp_instr;

   instruction_fetch #(
      .TIMEOUT_CYCLES (T),
      .RESET_INSTR    (RST_INS)
   ) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_PC             (i_PC),
      .i_fetch          (i_fetch),
      .i_flush          (i_flush),
      .o_mem_address    (o_mem_address),
      .o_mem_read       (o_mem_read),
      .i_mem_data       (i_mem_data),
      .i_mem_DV         (i_mem_DV),
      .o_instruction    (o_instruction),
      .o_instruction_DV (o_instruction_DV),
      .o_busy           (o_busy),
      .o_misaligned     (o_misaligned),
      .o_bus_fault      (o_bus_fault)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Watchdog: the bench must always end by itself.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One fetch. dv_k and flush_k are WAIT-relative cycles (k = 0 is the first
   // cycle with o_mem_read high); -1 means the event never happens. extra is
   // the number of idle cycles to observe after the fetch completes.
   task automatic run_txn(input logic [31:0] pc, input int dv_k, input int flush_k,
                          input logic [31:0] data, input int extra);
      int endk;
      bit dv_win, capt, flt;
      dv_win = (dv_k >= 1) && (dv_k <= T - 1);
      if (dv_win) begin
         endk = dv_k;
         capt = (flush_k < 0) || (flush_k > dv_k);
         flt  = 1'b0;
      end else begin
         capt = 1'b0;
         flt  = (flush_k < 0) || (flush_k > T - 1);
         endk = (flush_k == T - 1) ? T : T - 1;
      end

      i_PC    = pc;
      i_fetch = 1'b1;
      tick();
      i_fetch = 1'b0;
      check("addr", o_mem_address, pc);
      check("read_start", {31'd0, o_mem_read}, 32'd1);
      check("busy_start", {31'd0, o_busy}, 32'd1);

      for (int k = 0; k <= endk + extra; k++) begin
         i_mem_DV   = (k == dv_k);
         i_mem_data = (k == dv_k) ? data : $urandom;
         i_flush    = (k == flush_k);
         tick();
         i_mem_DV = 1'b0;
         i_flush  = 1'b0;
         if ((k == endk) && capt) exp_instr = data;
         check("busy",  {31'd0, o_busy},           {31'd0, (k < endk)});
         check("read",  {31'd0, o_mem_read},       {31'd0, (k < endk)});
         check("dv",    {31'd0, o_instruction_DV}, {31'd0, ((k == endk) && capt)});
         check("fault", {31'd0, o_bus_fault},      {31'd0, ((k == endk) && flt)});
         check("mis",   {31'd0, o_misaligned},     32'd0);
         check("instr", o_instruction, exp_instr);
      end
   endtask

   task automatic run_mis(input logic [31:0] pc);
      i_PC    = pc;
      i_fetch = 1'b1;
      tick();
      i_fetch = 1'b0;
      check("mis_pulse", {31'd0, o_misaligned}, 32'd1);
      check("mis_read",  {31'd0, o_mem_read},   32'd0);
      check("mis_busy",  {31'd0, o_busy},       32'd0);
      tick();
      check("mis_clear", {31'd0, o_misaligned}, 32'd0);
      check("mis_read2", {31'd0, o_mem_read},   32'd0);
      check("mis_busy2", {31'd0, o_busy},       32'd0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      exp_instr  = RST_INS;
      i_rst_n    = 1'b0;
      i_PC       = 32'h0;
      i_fetch    = 1'b0;
      i_flush    = 1'b0;
      i_mem_data = 32'h0;
      i_mem_DV   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_instr", o_instruction, RST_INS);
      check("rst_addr",  o_mem_address, 32'h80000000);
      check("rst_read",  {31'd0, o_mem_read},       32'd0);
      check("rst_busy",  {31'd0, o_busy},           32'd0);
      check("rst_dv",    {31'd0, o_instruction_DV}, 32'd0);
      check("rst_mis",   {31'd0, o_misaligned},     32'd0);
      check("rst_fault", {31'd0, o_bus_fault},      32'd0);
      i_rst_n = 1'b1;
      tick();

      // Basic fetch: response two cycles after o_mem_read rises
      run_txn(32'h80000000, 2, -1, 32'h00500093, 2);
      // Flush in the first WAIT cycle, response arrives later in DRAIN
      run_txn(32'h80000004, 3, 0, 32'hDEADBEEF, 1);
      // Response and flush in the same WAIT cycle, then a normal fetch
      run_txn(32'h80000008, 2, 2, 32'hCAFEF00D, 0);
      run_txn(32'h80000100, 1, -1, $urandom, 1);
      // Back-to-back fetches
      run_txn(32'h80000104, 1, -1, 32'h12345678, 0);
      run_txn(32'h80000108, 3, -1, 32'h9ABCDEF0, 1);

      // Misaligned PCs
      run_mis(32'h80000002);
      run_mis(32'h80000001);
      run_mis(32'h80000003);

      // A flush in the same cycle as a fetch request blocks the request
      i_PC    = 32'h80000200;
      i_fetch = 1'b1;
      i_flush = 1'b1;
      tick();
      i_fetch = 1'b0;
      i_flush = 1'b0;
      check("idle_flush_busy", {31'd0, o_busy},     32'd0);
      check("idle_flush_read", {31'd0, o_mem_read}, 32'd0);

      // Timeouts: fault in WAIT, silent ends after a flush into DRAIN
      run_txn(32'h80000300, -1, -1, 32'h0, 1);
      run_txn(32'h80000304, -1, 0, 32'h0, 1);
      run_txn(32'h80000308, -1, T - 1, 32'h0, 1);
      run_txn(32'h8000030C, 5, -1, 32'h11111111, 3);

      // Async reset mid-WAIT, then a late response after release
      i_PC    = 32'h80000400;
      i_fetch = 1'b1;
      tick();
      i_fetch = 1'b0;
      tick();
      check("pre_rst_read", {31'd0, o_mem_read}, 32'd1);
      #3;
      i_rst_n = 1'b0;
      #1;
      exp_instr = RST_INS;
      check("arst_read",  {31'd0, o_mem_read}, 32'd0);
      check("arst_busy",  {31'd0, o_busy},     32'd0);
      check("arst_instr", o_instruction, RST_INS);
      check("arst_addr",  o_mem_address, 32'h80000000);
      tick();
      i_rst_n    = 1'b1;
      i_mem_DV   = 1'b1;
      i_mem_data = 32'hBADC0DE5;
      tick();
      i_mem_DV = 1'b0;
      check("late_dv",    {31'd0, o_instruction_DV}, 32'd0);
      check("late_instr", o_instruction, RST_INS);
      check("late_busy",  {31'd0, o_busy}, 32'd0);
      run_txn(32'h80000404, 2, -1, 32'h00A00113, 1);

      // Randomized fetches
      for (int n = 0; n < 40; n++) begin
         logic [31:0] pc;
         int r, dvk, flk;
         pc = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            if (pc[1:0] == 2'b00) pc[0] = 1'b1;
            run_mis(pc);
         end else begin
            pc[1:0] = 2'b00;
            r   = $urandom_range(0, 5);
            dvk = (r == 0) ? -1 : r;
            flk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T)) : -1;
            run_txn(pc, dvk, flk, $urandom, $urandom_range(0, 2));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- On a fetch request it takes the current PC, issues one word read on the instruction memory bus, and captures the returned instruction.
- It emits a one-cycle instruction-valid pulse, which the control unit also uses as the PC load strobe.
- Handles flush (redirect) with in-flight reads, misaligned PCs and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: number of WAIT-state cycles without i_mem_DV before a bus fault is raised; legal range ≥1.
- RESET_INSTR, 32'h00000013: value of o_instruction after reset (RV32I NOP).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_PC  input  32  current PC from program counter.
- i_fetch  input  1  request a fetch of i_PC (level; sampled only in IDLE).
- i_flush  input  1  abort current/pending fetch (taken jump/trap).
- o_mem_address  output  32  instruction memory word address.
- o_mem_read  output  1  read request, held until response.
- i_mem_data  input  32  read data.
- i_mem_DV  input  1  read data valid, one cycle per request.
- o_instruction  output  32  last fetched instruction, stable until next capture.
- o_instruction_DV  output  1  one-cycle pulse: o_instruction is new.
- o_busy  output  1  high in WAIT or DRAIN.
- o_misaligned  output  1  one-cycle pulse: fetch requested with i_PC[1:0] != 0.
- o_bus_fault  output  1  one-cycle pulse: read timed out.

Behaviour:
- Reset (async assert, sync release) drives all outputs and internal state to these values:
  - state IDLE
  - o_mem_read 0
  - o_mem_address 32'h80000000
  - o_instruction RESET_INSTR
  - o_instruction_DV, o_misaligned, o_bus_fault, o_busy 0
  - timeout counter 0
- Reset mid-fetch abandons the read immediately. Memory must tolerate the dropped request.
- All outputs are registered.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - If i_flush is high, the request is ignored and the state stays IDLE.
  - Else if i_fetch is high and i_PC[1:0] != 0: o_misaligned pulses the next cycle, no bus access, stay IDLE.
  - Else if i_fetch is high: o_mem_address <= i_PC, o_mem_read <= 1, counter <= 0, go to WAIT.
- WAIT, checked in this priority order:
  - i_mem_DV and i_flush both high: data discarded, no DV pulse, o_mem_read <= 0, go to IDLE.
  - i_mem_DV high: o_instruction <= i_mem_data, o_instruction_DV pulses 1 the next cycle, o_mem_read <= 0, go to IDLE.
  - i_flush high: go to DRAIN with o_mem_read still 1.
  - counter == TIMEOUT_CYCLES-1: o_bus_fault pulses, o_mem_read <= 0, go to IDLE.
  - Otherwise counter += 1.
- DRAIN:
  - o_mem_read held at 1.
  - On i_mem_DV: data discarded, o_mem_read <= 0, go to IDLE.
  - Timeout uses the same counter, continuing from WAIT; it returns to IDLE silently with no o_bus_fault.
  - Further i_flush pulses have no effect.
- Memory responds at the earliest one cycle after o_mem_read first rises.
- Minimum fetch latency: i_fetch sampled (cycle 0) → o_mem_read high (cycle 1) → i_mem_DV (cycle ≥2) → o_instruction_DV (cycle ≥3).
- Back-to-back: a new i_fetch can be accepted in the cycle o_instruction_DV is high. PC is updated on that same edge, so the control unit must hold i_fetch low in that cycle.
- i_fetch in WAIT/DRAIN is ignored; no queueing. i_mem_DV in IDLE is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1) bits, no wrap possible.

Test Plan:
- Basic fetch:
  - Stimulus: reset, i_PC=32'h80000000, i_fetch pulse; memory returns 32'h00500093 two cycles after o_mem_read.
  - Required: o_mem_address=32'h80000000; o_instruction=32'h00500093 with a single o_instruction_DV pulse at cycle 4; o_mem_read low afterwards.
- Flush in flight:
  - Stimulus: fetch 32'h80000004, i_flush in the first WAIT cycle, memory answers 5 cycles later with 32'hDEADBEEF.
  - Required: no o_instruction_DV, o_instruction unchanged; o_busy high through DRAIN; IDLE the cycle after DV.
- Simultaneous DV and flush in WAIT:
  - Stimulus: i_mem_DV and i_flush in the same cycle.
  - Required: no DV pulse; next fetch of 32'h80000100 proceeds normally.
- Misaligned:
  - Stimulus: i_PC=32'h80000002 with i_fetch.
  - Required: o_misaligned one-cycle pulse; o_mem_read never asserted; o_busy 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, memory never responds.
  - Required: o_bus_fault pulses exactly once after 4 WAIT cycles; o_mem_read drops; same timing in DRAIN gives no fault.
- Async reset mid-WAIT:
  - Stimulus: assert i_rst_n low between clock edges.
  - Required: o_mem_read and o_busy drop immediately; o_instruction=32'h00000013; a late i_mem_DV after release is ignored.
